gcd_job_sequencer: RTL

Front-end stage that sits directly upstream of the GCD controller/datapath pair. It accepts operand pairs over a valid/ready stream and handles zero operands itself, because the subtractive core never terminates on a zero. It drives the core's go pulse and holds its operands stable, waits for done, and captures the result into a one-entry output register with valid/ready. A watchdog aborts a core that never finishes.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_watchdog.sv | 29 ++
 rtl/gcd_job_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default sizing for the GCD job path
package gcd_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ABORT = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_watchdog.sv
// rtl/gcd_watchdog.sv - cycle counter that flags a core stuck past TIMEOUT wait cycles
module gcd_watchdog
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = GCD_TIMEOUT,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic            expired,
  output logic [TO_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the last permitted cycle so the owner can leave before a further count.
  assign expired = enable && (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_job_sequencer.sv
// rtl/gcd_job_sequencer.sv - issues operand pairs to the GCD core, short-circuits zeros,
// aborts hung jobs and holds the result in a one-entry output register
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             go,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             core_rst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy
);

  gcd_state_e       state, state_nx;
  logic             accept, drain;
  logic             load, load_err;
  logic [WIDTH-1:0] load_gcd;
  logic             wd_expired;
  logic [TO_W-1:0]  wd_count_unused;

  // Only take a new pair when the result slot is (or is about to be) free,
  // so a finishing job always has somewhere to land.
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign go       = (state == ST_ISSUE);
  assign core_rst = (state == ST_ABORT);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_gcd = '0;
    load_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_a != '0 && in_b != '0) begin
            state_nx = ST_ISSUE;
          end else begin
            // The subtractive core never terminates on zero; answer here.
            load     = 1'b1;
            load_gcd = (in_a == '0) ? in_b : in_a;
            load_err = (in_a == '0) && (in_b == '0);
          end
        end
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          load     = 1'b1;
          load_gcd = core_result;
          state_nx = ST_IDLE;
        end else if (wd_expired) begin
          state_nx = ST_ABORT;
        end
      end
      ST_ABORT: begin
        load     = 1'b1;
        load_err = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a <= in_a;
        op_b <= in_b;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_gcd   <= load_gcd;
        out_err   <= load_err;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  gcd_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .expired(wd_expired),
    .count  (wd_count_unused)
  );

endmodule
